tdc_fifo_arbiter: RTL
=====================

// Module: tdc_fifo_arbiter
// PURPOSE
//  Shares one 32-bit result FIFO between N_CH TDC measurement controllers.
//  Each controller raises its write request with a 32-bit word {calib_diff, time1} and holds it.
//  The arbiter grants requesters round-robin, issues one FIFO write per grant, and returns a
//  one-cycle done pulse to the served controller. That pulse is the controller's FIFO feedback.
//  Sits between the per-channel tdc_control instances and the shared FIFO / readout path.
// PARAMETERS
//  N_CH         4        number of requesting TDC channels (2..8)
//  CH_W         2        channel-index width, must equal clog2(N_CH)
//  DROP_TIMEOUT 1000     cycles a request may wait on fifo_full before being dropped (only with TDC_ARB_DROP_EN)
// PORTS
//  clk          in   1        system clock
//  rst          in   1        synchronous, active-high reset
//  req_wr_en    in   N_CH     per-channel write request, level, held by requester until its done pulse
//  req_data     in   32*N_CH  per-channel data word; channel k occupies [32k+31:32k]
//  req_done     out  N_CH     per-channel one-cycle "writing done" pulse
//  fifo_full    in   1        shared FIFO full flag
//  fifo_wr_en   out  1        shared FIFO write strobe, one cycle per accepted word
//  fifo_din     out  32       shared FIFO write data
//  fifo_ch      out  CH_W     channel index of the current fifo_din (sideband for the readout)
//  busy         out  1        high whenever the FSM is not in ARB
//  drop_count   out  16*N_CH  per-channel dropped-request counters, saturating; all zero without TDC_ARB_DROP_EN
// BEHAVIOUR
//  Reset (rst=1 at a clk edge; overrides everything, including mid-transaction):
//   - state=ARB, rr_ptr=0, all outputs 0, drop_count=0.
//   - armed[]=0.
//  Arming:
//   - armed[k] is set when req_wr_en[k] is sampled low.
//   - armed[k] is cleared when channel k is granted or dropped.
//   - valid[k] = req_wr_en[k] & armed[k].
//   - Effect: a request held high across reset, or still high in the cycle after its done pulse,
//     is never served twice.
//  Round-robin:
//   - Search starts at rr_ptr and wraps N_CH-1 -> 0.
//   - The first valid channel wins.
//   - After a grant or drop of channel g, rr_ptr = (g+1) mod N_CH.
//   - After reset, channel 0 has highest priority.
//  FSM (one-hot or binary; 3 states):
//   - ARB:
//     - If any valid and !fifo_full: latch winner index and data into the fifo_ch/fifo_din registers,
//       clear armed[winner], go to WRITE.
//     - Else stay in ARB.
//   - WRITE:
//     - fifo_wr_en=1 for exactly this one cycle; fifo_din/fifo_ch hold the latched values.
//     - Go to ACK.
//   - ACK:
//     - req_done[ch]=1 for exactly this one cycle (one bit only); fifo_wr_en=0.
//     - Go to ARB.
//  Latency and throughput:
//   - Request sampled in ARB at edge t.
//   - fifo_wr_en high during cycle t+1.
//   - req_done high during cycle t+2.
//   - Next grant decision can happen at the t+3 edge, giving at most 1 word per 3 cycles.
//  Other rules:
//   - fifo_din/fifo_ch keep their last value outside WRITE. Only fifo_wr_en qualifies them.
//   - fifo_full is checked only in ARB. The FIFO must assert full combinationally/registered
//     no later than the cycle after the write that fills it. A write issued in WRITE is never cancelled.
//   - Simultaneous requests are served strictly in round-robin order. No channel waits more than
//     N_CH-1 grants while valid and the FIFO is not full.
//   - A requester dropping req_wr_en before being granted simply withdraws the request; no done pulse is sent.
// CONFIGURATION
//  TDC_ARB_DROP_EN defined:
//   - In ARB, wait_cnt increments each cycle with (any valid & fifo_full).
//   - wait_cnt clears on any grant, on any drop, or when no request is valid.
//   - When wait_cnt reaches DROP_TIMEOUT, the round-robin winner is dropped:
//     - go to ACK without WRITE, so no fifo_wr_en;
//     - req_done pulses for that channel, armed cleared, rr_ptr advances;
//     - drop_count[ch] increments, saturating at 16'hFFFF.
//  TDC_ARB_DROP_EN undefined:
//   - Requests wait on fifo_full indefinitely (pure backpressure).
//   - No wait counter; drop_count tied to 0.
// TESTING
//  1. Single request: req_wr_en[2]=1 with data 32'h12AB_0190, FIFO empty -> fifo_wr_en one cycle later with
//     din=32'h12AB_0190, ch=2; req_done[2] pulses the next cycle. Holding req_wr_en[2] high afterwards causes
//     no second write.
//  2. All four channels request in the same cycle after reset -> writes occur in order ch0,1,2,3,
//     3 cycles apart, each with its own data and one done pulse.
//  3. Round-robin fairness: ch1 is served, then ch0 and ch1 re-request together -> ch0 is served
//     first (rr_ptr=2 wraps to 0).
//  4. fifo_full=1 with ch3 requesting -> no fifo_wr_en and no done while full. Full drops -> write issued
//     within 2 cycles. With TDC_ARB_DROP_EN and DROP_TIMEOUT=10: full held 20 cycles -> ch3 done without a
//     write, drop_count[3]=1.
//  5. rst asserted in WRITE/ACK while req_wr_en[1] stays high -> all outputs 0 next cycle. Ch1 is not served
//     until it drops req_wr_en low and raises it again.

Source files
------------

// File: rtl/tdc_fifo_arbiter.sv
// tdc_fifo_arbiter: round-robin arbiter sharing one 32-bit result FIFO between N_CH TDC channels.
// Optional feature macro TDC_ARB_DROP_EN: drop a request that waits DROP_TIMEOUT cycles on a full FIFO.
module tdc_fifo_arbiter #(
  parameter int N_CH         = 4,
  parameter int CH_W         = 2,
  parameter int DROP_TIMEOUT = 1000
) (
  input  logic                 i_clk,
  input  logic                 i_rst,
  input  logic [N_CH-1:0]      i_req_wr_en,
  input  logic [32*N_CH-1:0]   i_req_data,
  output logic [N_CH-1:0]      o_req_done,
  input  logic                 i_fifo_full,
  output logic                 o_fifo_wr_en,
  output logic [31:0]          o_fifo_din,
  output logic [CH_W-1:0]      o_fifo_ch,
  output logic                 o_busy,
  output logic [16*N_CH-1:0]   o_drop_count
);

  typedef enum logic [1:0] {
    ST_ARB   = 2'd0,
    ST_WRITE = 2'd1,
    ST_ACK   = 2'd2
  } state_t;

  function automatic logic [N_CH-1:0] onehot(input logic [CH_W-1:0] idx);
    logic [N_CH-1:0] v;
    v      = '0;
    v[idx] = 1'b1;
    return v;
  endfunction

  state_t            r_state;
  state_t            w_state_nxt;
  logic [N_CH-1:0]   r_armed;
  logic [N_CH-1:0]   w_valid;
  logic [N_CH-1:0]   w_clr;
  logic [CH_W-1:0]   r_rr_ptr;
  logic [CH_W-1:0]   w_win;
  logic [CH_W-1:0]   w_idx;
  logic              w_any;
  logic              w_grant;
  logic              w_drop;
  logic [31:0]       w_words [N_CH];
  logic              r_fifo_wr_en;
  logic [31:0]       r_fifo_din;
  logic [CH_W-1:0]   r_fifo_ch;
  logic [N_CH-1:0]   r_req_done;
  logic              r_busy;

  // Armed gating: a request must be seen low once before it can be served again.
  assign w_valid = i_req_wr_en & r_armed;
  assign w_grant = (r_state == ST_ARB) && w_any && !i_fifo_full;
  assign w_clr   = (w_grant || w_drop) ? onehot(w_win) : '0;

  // Split the flat request bus into per-channel words.
  always_comb begin
    for (int k = 0; k < N_CH; k++) begin
      w_words[k] = i_req_data[32*k +: 32];
    end
  end

  // Round-robin search from rr_ptr, first valid channel wins.
  always_comb begin
    w_win = '0;
    w_any = 1'b0;
    w_idx = '0;
    for (int i = 0; i < N_CH; i++) begin
      w_idx = CH_W'((int'(r_rr_ptr) + i) % N_CH);
      w_win = (!w_any && w_valid[w_idx]) ? w_idx : w_win;
      w_any = w_any | w_valid[w_idx];
    end
  end

  // State register.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state <= ST_ARB;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next-state logic.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_ARB: begin
        if (w_grant) begin
          w_state_nxt = ST_WRITE;
        end else if (w_drop) begin
          w_state_nxt = ST_ACK;
        end else begin
          w_state_nxt = ST_ARB;
        end
      end
      ST_WRITE: w_state_nxt = ST_ACK;
      ST_ACK:   w_state_nxt = ST_ARB;
      default:  w_state_nxt = ST_ARB;
    endcase
  end

  // Registered outputs, arming and round-robin pointer.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_fifo_wr_en <= 1'b0;
      r_fifo_din   <= 32'h0000_0000;
      r_fifo_ch    <= '0;
      r_req_done   <= '0;
      r_busy       <= 1'b0;
      r_armed      <= '0;
      r_rr_ptr     <= '0;
    end else begin
      r_fifo_wr_en <= (w_state_nxt == ST_WRITE);
      r_busy       <= (w_state_nxt != ST_ARB);
      r_armed      <= (r_armed | ~i_req_wr_en) & ~w_clr;
      if (w_grant) begin
        r_fifo_din <= w_words[w_win];
        r_fifo_ch  <= w_win;
      end
      // A dropped request is acknowledged straight from ARB, with no write.
      if (r_state == ST_WRITE) begin
        r_req_done <= onehot(r_fifo_ch);
      end else if (w_drop) begin
        r_req_done <= onehot(w_win);
      end else begin
        r_req_done <= '0;
      end
      if (w_grant || w_drop) begin
        r_rr_ptr <= (w_win == CH_W'(N_CH - 1)) ? '0 : w_win + CH_W'(1);
      end
    end
  end

`ifdef TDC_ARB_DROP_EN
  localparam int WAIT_W = $clog2(DROP_TIMEOUT + 1);

  logic [WAIT_W-1:0]      r_wait_cnt;
  logic [N_CH-1:0][15:0]  r_drop_count;

  assign w_drop = (r_state == ST_ARB) && w_any && i_fifo_full &&
                  (r_wait_cnt == WAIT_W'(DROP_TIMEOUT));

  // Full-FIFO wait counter and saturating per-channel drop counters.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_wait_cnt   <= '0;
      r_drop_count <= '0;
    end else begin
      if (r_state == ST_ARB) begin
        if (w_grant || w_drop || !w_any) begin
          r_wait_cnt <= '0;
        end else begin
          r_wait_cnt <= r_wait_cnt + WAIT_W'(1);
        end
      end
      if (w_drop && (r_drop_count[w_win] != 16'hFFFF)) begin
        r_drop_count[w_win] <= r_drop_count[w_win] + 16'd1;
      end
    end
  end

  assign o_drop_count = r_drop_count;
`else
  assign w_drop       = 1'b0;
  assign o_drop_count = '0;
`endif

  assign o_fifo_wr_en = r_fifo_wr_en;
  assign o_fifo_din   = r_fifo_din;
  assign o_fifo_ch    = r_fifo_ch;
  assign o_req_done   = r_req_done;
  assign o_busy       = r_busy;

endmodule
